uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  - Elastic buffer directly downstream of the UART receiver (uart_rx / uart_top rx_valid, rx_data).
//  - Absorbs received words; the receiver cannot be stalled, so the write side has no backpressure.
//  - Presents words to the consumer on a valid/ready stream with first-word-fall-through.
//  - Flags overflow (word lost) and reports fill level for software/flow-control logic.
// PARAMETERS
//  W_OUT   24  data word width; matches receiver m_data width
//  DEPTH   16  number of entries; power of two, >= 2
//  LVL_W   $clog2(DEPTH+1)  localparam, width of level output
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rstn       in   1       asynchronous active-low reset
//  s_valid    in   1       receiver word valid (1-cycle pulse per word)
//  s_data     in   W_OUT   receiver word
//  m_valid    out  1       head word available
//  m_data     out  W_OUT   head word (stable while m_valid && !m_ready)
//  m_ready    in   1       consumer accepts head word
//  flush      in   1       synchronous clear of contents
//  ovf_clr    in   1       clear sticky overflow flag
//  level      out  LVL_W   current number of stored words, 0..DEPTH
//  full       out  1       level == DEPTH
//  overflow   out  1       sticky: a word was dropped
//  ovf_count  out  16      dropped-word counter (UART_RX_FIFO_OVF_CNT_EN only)
// BEHAVIOUR
//  - Reset (rstn=0, async): wr/rd pointers 0, level 0, m_valid 0, m_data 0, full 0,
//    overflow 0, ovf_count 0. Memory contents not reset.
//  - Pointers log2(DEPTH)+1 bits; wrap naturally; full/empty from MSB compare; level = wr-rd.
//  - Write: s_valid && (!full || pop) -> store at wr_ptr, wr_ptr+1.
//  - Pop: m_valid && m_ready -> rd_ptr+1 same cycle.
//  - Latency: word written into empty FIFO at edge N visible on m_valid/m_data after edge N+1.
//    Never combinational from s_data to m_data.
//  - m_valid = !empty (registered view); m_data holds head until popped.
//  - Full and s_valid with no pop -> word dropped, contents unchanged, overflow<=1 next edge.
//  - Full and s_valid with pop same cycle -> write accepted, level stays DEPTH, no overflow.
//  - Empty and s_valid and m_ready -> no pop (m_valid was 0); word stored, level 1.
//  - flush=1 -> pointers 0, m_valid 0, level 0 next edge; simultaneous s_valid is dropped
//    but does NOT set overflow; simultaneous pop ignored.
//  - ovf_clr=1 -> overflow<=0; if a drop occurs in the same cycle, set wins (overflow=1).
//  - level/full are registered-consistent with pointers (update on the same edge).
//  - Reset asserted mid-stream: all stored words discarded, outputs to reset values at once.
// CONFIGURATION
//  - Macro UART_RX_FIFO_OVF_CNT_EN.
//  - Defined: ovf_count port present; +1 per dropped word, saturates at 16'hFFFF,
//    cleared by ovf_clr (clr and drop same cycle -> count = 1); not cleared by flush.
//  - Undefined: ovf_count port and counter absent; overflow flag behaviour unchanged.
// TESTING
//  - Write 24'hA5A5A5 into empty FIFO, m_ready=0 -> m_valid=1 and m_data=A5A5A5 one cycle
//    after write edge, level=1; assert m_ready one cycle -> m_valid=0, level=0.
//  - Write 16 words 0..15 with m_ready=0 -> full=1, level=16; write 24'h0000FF -> dropped,
//    overflow=1; drain -> reads 0..15 in order, 0xFF never appears.
//  - Full FIFO, s_valid and m_ready same cycle -> level stays 16, overflow stays 0,
//    new word read last.
//  - 5 words stored, flush with s_valid=1 -> level=0, m_valid=0, overflow=0 next cycle.
//  - Overflow set, ovf_clr pulse -> overflow=0; ovf_clr coincident with a drop -> overflow=1;
//    with UART_RX_FIFO_OVF_CNT_EN, 3 drops -> ovf_count=3.
//  - rstn low while 8 words stored -> level=0, m_valid=0 asynchronously; pointer wrap
//    exercised by 40 back-to-back write/read pairs with data checked.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Elastic FWFT buffer behind the UART receiver: no write backpressure, sticky overflow, fill level.
// Optional dropped-word counter on ovf_count when UART_RX_FIFO_OVF_CNT_EN is defined.
module uart_rx_fifo #(
    parameter  int W_OUT = 24,
    parameter  int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    input  logic [W_OUT-1:0] s_data,
    output logic             m_valid,
    output logic [W_OUT-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush,
    input  logic             ovf_clr,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             overflow
`ifdef UART_RX_FIFO_OVF_CNT_EN
    ,
    output logic [15:0]      ovf_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [W_OUT-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             pop;
    logic             push;
    logic             drop;
    logic             head_load;
    logic             full_next;
    logic [LVL_W-1:0] level_next;

    always_comb begin
        pop        = m_valid && m_ready && !flush;
        push       = s_valid && !flush && (!full || pop);
        drop       = s_valid && !flush && full && !pop;
        wr_next    = flush ? '0 : wr_ptr + (AW+1)'(push);
        rd_next    = flush ? '0 : rd_ptr + (AW+1)'(pop);
        level_next = LVL_W'(wr_next - rd_next);
        full_next  = (wr_next[AW] != rd_next[AW]) &&
                     (wr_next[AW-1:0] == rd_next[AW-1:0]);
        // Head becomes visible only from words stored before this edge, so
        // s_data never reaches m_data in the cycle it is written.
        head_load  = !flush && (wr_ptr != rd_next);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            level   <= level_next;
            full    <= full_next;
            m_valid <= head_load;
            if (head_load) begin
                m_data <= mem[rd_next[AW-1:0]];
            end
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_OVF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            ovf_count <= sat_inc(ovf_count);
        end
    end
`endif

endmodule
